// File: rtl/exec_writeback.sv
// Execute/write-back stage of processor Z: six-entry register file, E->W ALU pipeline
// with E/W operand forwarding, condition codes and a sticky illegal-instruction flag.
module exec_writeback #(
  parameter int unsigned NREG = 6,
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            in_valid,
  input  logic [3:0]      icode,
  input  logic [3:0]      ifun,
  input  logic [3:0]      rA,
  input  logic [3:0]      rB,
  input  logic [15:0]     valC,
  output logic            wb_valid,
  output logic [3:0]      wb_dst,
  output logic [XLEN-1:0] wb_val,
  output logic            zf,
  output logic            sf,
  output logic            of,
  output logic            err,
  input  logic [3:0]      dbg_sel,
  output logic [XLEN-1:0] dbg_dat
);

  localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [3:0] IC_IRMOV = 4'h3;
  localparam logic [3:0] IC_OP    = 4'h6;
  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] NREG_ID  = 4'(NREG);

  logic [XLEN-1:0] rf [NREG];

  logic            e_valid;
  logic [3:0]      e_dst;
  logic [XLEN-1:0] e_res;
  logic            e_is_op;
  logic            e_of;

  logic            is_irmov, is_op, legal, accept;
  logic [XLEN-1:0] op_a, op_b, sum, diff, alu_res;
  logic            alu_of;

  // Decode legality; a set err blocks all further acceptance
  always_comb begin
    is_irmov = (icode == IC_IRMOV) && (ifun == 4'd0) && (rA == REG_NONE) && (rB < NREG_ID);
    is_op    = (icode == IC_OP) && (ifun <= 4'd3) && (rA < NREG_ID) && (rB < NREG_ID);
    legal    = is_irmov || is_op;
    accept   = in_valid && !err;
  end

  // Operand read: the youngest in-flight producer (E) wins over W, which wins over the file
  always_comb begin
    op_a = '0;
    op_b = '0;
    if (rA < NREG_ID) op_a = rf[rA[IW-1:0]];
    if (wb_valid && (wb_dst == rA)) op_a = wb_val;
    if (e_valid && (e_dst == rA)) op_a = e_res;
    if (rB < NREG_ID) op_b = rf[rB[IW-1:0]];
    if (wb_valid && (wb_dst == rB)) op_b = wb_val;
    if (e_valid && (e_dst == rB)) op_b = e_res;
  end

  // ALU; SUB is R[rB] - R[rA]
  always_comb begin
    sum     = op_b + op_a;
    diff    = op_b - op_a;
    alu_res = '0;
    alu_of  = 1'b0;
    if (icode == IC_IRMOV) begin
      alu_res = XLEN'(valC);
    end else begin
      case (ifun[1:0])
        2'd0: begin
          alu_res = sum;
          alu_of  = (op_a[XLEN-1] == op_b[XLEN-1]) && (sum[XLEN-1] != op_b[XLEN-1]);
        end
        2'd1: begin
          alu_res = diff;
          alu_of  = (op_a[XLEN-1] != op_b[XLEN-1]) && (diff[XLEN-1] != op_b[XLEN-1]);
        end
        2'd2:    alu_res = op_b & op_a;
        default: alu_res = op_b ^ op_a;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
      e_valid  <= 1'b0;
      e_dst    <= '0;
      e_res    <= '0;
      e_is_op  <= 1'b0;
      e_of     <= 1'b0;
      wb_valid <= 1'b0;
      wb_dst   <= '0;
      wb_val   <= '0;
      zf       <= 1'b0;
      sf       <= 1'b0;
      of       <= 1'b0;
      err      <= 1'b0;
    end else begin
      // W stage: retire whatever E holds
      wb_valid <= e_valid;
      if (e_valid) begin
        rf[e_dst[IW-1:0]] <= e_res;
        wb_dst            <= e_dst;
        wb_val            <= e_res;
        if (e_is_op) begin
          zf <= (e_res == '0);
          sf <= e_res[XLEN-1];
          of <= e_of;
        end
      end
      // E stage
      e_valid <= accept && legal;
      if (accept && legal) begin
        e_dst   <= rB;
        e_res   <= alu_res;
        e_is_op <= is_op;
        e_of    <= alu_of;
      end
      if (accept && !legal) err <= 1'b1;
    end
  end

  assign dbg_dat = (dbg_sel < NREG_ID) ? rf[dbg_sel[IW-1:0]] : '0;

endmodule
